// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for the wide ALU sequencer.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDC = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_GT   = 3'b101;
   localparam logic [2:0] OP_SHLA = 3'b110;
   localparam logic [2:0] OP_SHLB = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   function automatic logic is_add(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_ADDC);
   endfunction

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SHLA) || (op == OP_SHLB);
   endfunction

endpackage

// File: rtl/alu_seq_collect.sv
// Per-byte write-back: accumulates result bytes, chains the carry/shift bit between
// bytes and merges the LSB-first compare state into a wide A>B.
module alu_seq_collect
   import alu_seq_pkg::*;
#(
   parameter  int unsigned NBYTES = 4,
   localparam int unsigned KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic                   init_bit,
   input  logic                   en,
   input  logic [KW-1:0]          k,
   input  logic [2:0]             opcode,
   input  logic [7:0]             a_byte,
   input  logic [7:0]             b_byte,
   input  logic [7:0]             alu_out,
   input  logic                   alu_carry_out,
   output logic                   chain,
   output logic [NBYTES-1:0][7:0] result_c,
   output logic                   carry_c,
   output logic                   gt_c
);

   logic [NBYTES-1:0][7:0] acc;
   logic                   gt_q;
   logic                   byte_gt;
   logic [7:0]             byte_res;
   logic                   chain_next;

   // Higher bytes override lower ones, so an unequal byte decides and an equal one keeps gt.
   always_comb begin
      byte_gt    = (opcode == OP_GT) ? alu_out[0] : (a_byte > b_byte);
      gt_c       = (a_byte != b_byte) ? byte_gt : gt_q;
      byte_res   = is_shift(opcode) ? (alu_out | {7'b0, chain}) : alu_out;
      chain_next = 1'b0;
      if (is_add(opcode)) begin
         chain_next = alu_carry_out;
      end else if (opcode == OP_SHLA) begin
         chain_next = a_byte[7];
      end else if (opcode == OP_SHLB) begin
         chain_next = b_byte[7];
      end
      carry_c     = chain_next;
      result_c    = acc;
      result_c[k] = byte_res;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         gt_q  <= 1'b0;
         chain <= 1'b0;
      end else if (load) begin
         acc   <= '0;
         gt_q  <= 1'b0;
         chain <= init_bit;
      end else if (en) begin
         acc   <= result_c;
         gt_q  <= gt_c;
         chain <= chain_next;
      end
   end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Drives an external 8-bit ALU one byte per cycle (LSB first) to execute an NBYTES-wide op.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds the registered o_zero result flag.
module alu_wide_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2:0]            i_opcode,
   input  logic [8*NBYTES-1:0]   i_a,
   input  logic [8*NBYTES-1:0]   i_b,
   input  logic                  i_carry_in,
   output logic [7:0]            o_alu_a,
   output logic [7:0]            o_alu_b,
   output logic [2:0]            o_alu_opcode,
   output logic                  o_alu_carry_in,
   input  logic [7:0]            i_alu_out,
   input  logic                  i_alu_carry_out,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [8*NBYTES-1:0]   o_result,
   output logic                  o_carry_out,
   output logic                  o_gt
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic                  o_zero
`endif
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

   seq_state_t             state;
   seq_state_t             state_next;
   logic [NBYTES-1:0][7:0] a_q;
   logic [NBYTES-1:0][7:0] b_q;
   logic [2:0]             op_q;
   logic [KW-1:0]          k;
   logic                   accept;
   logic                   issue;
   logic                   last_byte;
   logic                   chain;
   logic [NBYTES-1:0][7:0] result_c;
   logic                   carry_c;
   logic                   gt_c;
   logic [W-1:0]           final_c;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DONE with a waiting request chains straight into the next ISSUE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_valid) state_next = ISSUE;
         ISSUE:   if (k == K_LAST) state_next = DONE;
         DONE:    if (i_ready) state_next = i_valid ? ISSUE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_ready        = (state == IDLE) || ((state == DONE) && i_ready);
      accept         = i_valid && o_ready;
      issue          = (state == ISSUE);
      last_byte      = issue && (k == K_LAST);
      o_alu_a        = 8'h00;
      o_alu_b        = 8'h00;
      o_alu_opcode   = 3'b000;
      o_alu_carry_in = 1'b0;
      if (issue) begin
         o_alu_a = a_q[k];
         o_alu_b = b_q[k];
         if (is_add(op_q)) begin
            o_alu_opcode   = chain ? OP_ADDC : OP_ADD;
            o_alu_carry_in = chain;
         end else begin
            o_alu_opcode = op_q;
         end
      end
   end

   alu_seq_collect #(.NBYTES(NBYTES)) u_collect (
      .clk           (i_clk),
      .rst_n         (i_rst_n),
      .load          (accept),
      .init_bit      ((i_opcode == OP_ADDC) && i_carry_in),
      .en            (issue),
      .k             (k),
      .opcode        (op_q),
      .a_byte        (a_q[k]),
      .b_byte        (b_q[k]),
      .alu_out       (i_alu_out),
      .alu_carry_out (i_alu_carry_out),
      .chain         (chain),
      .result_c      (result_c),
      .carry_c       (carry_c),
      .gt_c          (gt_c)
   );

   // Compare reports only the wide gt bit in the result.
   assign final_c = (op_q == OP_GT) ? W'(gt_c) : result_c;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         k           <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_ADD;
         o_valid     <= 1'b0;
         o_result    <= '0;
         o_carry_out <= 1'b0;
         o_gt        <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         o_zero      <= 1'b0;
`endif
      end else begin
         o_valid <= (state_next == DONE);
         if (accept) begin
            k    <= '0;
            a_q  <= i_a;
            b_q  <= i_b;
            op_q <= i_opcode;
         end else if (issue) begin
            k <= k + KW'(1);
         end
         if (last_byte) begin
            o_result    <= final_c;
            o_carry_out <= carry_c;
            o_gt        <= gt_c;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            o_zero      <= (final_c == '0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench: 8-bit ALU model, wide-arithmetic reference model checked every
// result cycle, plus directed vectors with hand-computed literal results.
module tb_alu_wide_sequencer;

   localparam int unsigned NB = 4;
   localparam int unsigned W  = 8 * NB;
   localparam int unsigned W1 = W + 1;

   typedef struct {
      logic [W-1:0] result;
      logic         carry;
      logic         gt;
      logic         zero;
      int           acc_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [2:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic [7:0]   alu_a;
   logic [7:0]   alu_b;
   logic [2:0]   alu_op;
   logic         alu_cin;
   logic [7:0]   alu_out;
   logic         alu_cout;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_result;
   logic         o_carry_out;
   logic         o_gt;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic         o_zero;
`endif

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   head_seen = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [2:0] alu_ops [NB];

   always #5 clk = ~clk;

   alu_wide_sequencer #(.NBYTES(NB)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_opcode        (opcode),
      .i_a             (a),
      .i_b             (b),
      .i_carry_in      (carry_in),
      .o_alu_a         (alu_a),
      .o_alu_b         (alu_b),
      .o_alu_opcode    (alu_op),
      .o_alu_carry_in  (alu_cin),
      .i_alu_out       (alu_out),
      .i_alu_carry_out (alu_cout),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_result        (o_result),
      .o_carry_out     (o_carry_out),
      .o_gt            (o_gt)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      ,
      .o_zero          (o_zero)
`endif
   );

   // The external 8-bit ALU.
   logic [8:0] sum9;
   always_comb begin
      sum9     = 9'(alu_a) + 9'(alu_b) + 9'((alu_op == 3'b001) ? alu_cin : 1'b0);
      alu_out  = 8'h00;
      alu_cout = 1'b0;
      case (alu_op)
         3'b000, 3'b001: begin alu_out = sum9[7:0]; alu_cout = sum9[8]; end
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a | alu_b;
         3'b100:  alu_out = alu_a ^ alu_b;
         3'b101:  alu_out = {7'b0, alu_a > alu_b};
         3'b110:  alu_out = {alu_a[6:0], 1'b0};
         default: alu_out = {alu_b[6:0], 1'b0};
      endcase
   end

   // Whole-word reference for one operation.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic cin);
      exp_t       e;
      logic [W:0] s;
      e.result  = '0;
      e.carry   = 1'b0;
      e.gt      = (x > y);
      e.acc_cyc = 0;
      case (op)
         3'b000: begin s = {1'b0, x} + {1'b0, y}; e.result = s[W-1:0]; e.carry = s[W]; end
         3'b001: begin s = {1'b0, x} + {1'b0, y} + W1'(cin); e.result = s[W-1:0]; e.carry = s[W]; end
         3'b010: e.result = x & y;
         3'b011: e.result = x | y;
         3'b100: e.result = x ^ y;
         3'b101: e.result = W'(x > y);
         3'b110: begin e.result = x << 1; e.carry = x[W-1]; end
         default: begin e.result = y << 1; e.carry = y[W-1]; end
      endcase
      e.zero = (e.result == '0);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Compare process: every result cycle against the model, plus latency and ready.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         head_seen = 1'b0;
      end else begin
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_valid: o_valid=1 with result 0x%0h, want no result pending", o_result);
            end else begin
               mon_e = exp_q[0];
               check("mon_result", 64'(o_result), 64'(mon_e.result));
               check("mon_carry", 64'(o_carry_out), 64'(mon_e.carry));
               check("mon_gt", 64'(o_gt), 64'(mon_e.gt));
`ifdef ALU_SEQ_ZERO_FLAG_EN
               check("mon_zero", 64'(o_zero), 64'(mon_e.zero));
`endif
               check("mon_ready", 64'(o_ready), 64'(i_ready));
               // Accept is seen half a cycle before its edge, so NB cycles read as NB+1 negedges.
               if (!head_seen) begin
                  check("mon_latency", 64'(cyc - mon_e.acc_cyc), 64'(NB + 1));
                  head_seen = 1'b1;
               end
               if (i_ready) begin
                  void'(exp_q.pop_front());
                  head_seen = 1'b0;
               end
            end
         end
         if (i_valid && o_ready) begin
            mon_e         = model(opcode, a, b, carry_in);
            mon_e.acc_cyc = cyc;
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
      int n;
      opcode   = op;
      a        = x;
      b        = y;
      carry_in = cin;
      i_valid  = 1'b1;
      n        = 0;
      @(negedge clk);
      while (!o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: o_ready=0 after %0d cycles, want 1", n);
      end
      @(posedge clk); #1;
      i_valid  = 1'b0;
      a        = ~x;
      b        = x ^ y;
      opcode   = ~op;
      carry_in = ~cin;
      for (int i = 0; i < int'(NB); i++) begin
         @(negedge clk);
         alu_ops[i] = alu_op;
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_valid) begin
         tests++;
         fails++;
         $display("FAIL valid_timeout: o_valid=0 after %0d cycles, want 1", n);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                         output logic [W-1:0] r, output logic c, output logic g, output logic z);
      send(op, x, y, cin);
      wait_valid();
      r = o_result;
      c = o_carry_out;
      g = o_gt;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      z = o_zero;
`else
      z = (o_result == '0);
`endif
      @(posedge clk); #1;
   endtask

   logic [W-1:0] r;
   logic         c;
   logic         g;
   logic         z;
   logic [2:0]   tbl_op [6] = '{3'b000, 3'b001, 3'b101, 3'b101, 3'b110, 3'b011};
   logic [W-1:0] tbl_a  [6] = '{32'h7FFFFFFF, 32'h00001234, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h00C3000F};
   logic [W-1:0] tbl_b  [6] = '{32'h00000001, 32'h0000FFFF, 32'h0000FFFF, 32'h7FFFFFFF, 32'h00000000, 32'h3C0000F0};

   initial begin
      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      opcode   = 3'b000;
      a        = '0;
      b        = '0;
      carry_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_outputs", 64'({o_result, o_carry_out, o_gt}), 64'd0);
      check("rst_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
      @(posedge clk); #1;

      run_op(3'b000, 32'h00FFFFFF, 32'h00000001, 1'b0, r, c, g, z);
      check("add_result", 64'(r), 64'(32'h01000000));
      check("add_carry", 64'(c), 64'd0);
      check("add_alu_ops", 64'({alu_ops[3], alu_ops[2], alu_ops[1], alu_ops[0]}), 64'(12'b001_001_001_000));

      run_op(3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b1, r, c, g, z);
      check("addc_result", 64'(r), 64'd0);
      check("addc_carry", 64'(c), 64'd1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      check("addc_zero", 64'(z), 64'd1);
`endif

      run_op(3'b110, 32'h80808080, 32'h00000000, 1'b0, r, c, g, z);
      check("shla_result", 64'(r), 64'(32'h01010100));
      check("shla_carry", 64'(c), 64'd1);
      run_op(3'b111, 32'h00000000, 32'h40000001, 1'b0, r, c, g, z);
      check("shlb_result", 64'(r), 64'(32'h80000002));
      check("shlb_carry", 64'(c), 64'd0);

      run_op(3'b101, 32'h01000000, 32'h00FFFFFF, 1'b0, r, c, g, z);
      check("gt_result", 64'(r), 64'd1);
      check("gt_flag", 64'(g), 64'd1);
      run_op(3'b101, 32'h00FFFFFF, 32'h01000000, 1'b0, r, c, g, z);
      check("gt_swapped", 64'({r, g}), 64'd0);
      run_op(3'b101, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, r, c, g, z);
      check("gt_equal", 64'({r, g}), 64'd0);

      run_op(3'b010, 32'hF0F01234, 32'h0FF0FF00, 1'b0, r, c, g, z);
      check("and_result", 64'(r), 64'(32'h00F01200));
      check("and_gt", 64'(g), 64'd1);
      run_op(3'b011, 32'hF0F01234, 32'h0FF0FF00, 1'b0, r, c, g, z);
      check("or_result", 64'(r), 64'(32'hFFF0FF34));
      run_op(3'b100, 32'hF0F01234, 32'h0FF0FF00, 1'b0, r, c, g, z);
      check("xor_result", 64'({r, c}), 64'({32'hFF00ED34, 1'b0}));

      for (int i = 0; i < 6; i++) begin
         run_op(tbl_op[i], tbl_a[i], tbl_b[i], 1'b0, r, c, g, z);
      end

      // Held request with ready high: one op every NB+1 cycles.
      opcode   = 3'b001;
      a        = 32'h0000FFFF;
      b        = 32'h00000001;
      carry_in = 1'b1;
      i_valid  = 1'b1;
      repeat (11) @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Backpressure: result held, new request and operand changes ignored.
      i_ready = 1'b0;
      send(3'b000, 32'h12345678, 32'h11111111, 1'b0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(o_valid), 64'd1);
         check("bp_result", 64'(o_result), 64'(32'h23456789));
         check("bp_ready", 64'(o_ready), 64'd0);
         @(posedge clk); #1;
         if (i == 2) begin
            i_valid = 1'b1;
            opcode  = 3'b100;
            a       = 32'hA5A5A5A5;
            b       = 32'h0F0F0F0F;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      i_ready = 1'b1;
      @(negedge clk);
      check("direct_accept_ready", 64'(o_ready), 64'd1);
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      check("direct_accept_issue", 64'(o_valid), 64'd0);
      wait_valid();
      check("direct_result", 64'(o_result), 64'(32'hAAAAAAAA));
      @(posedge clk); #1;

      // Reset while byte 2 is on the ALU port.
      opcode   = 3'b000;
      a        = 32'h01020304;
      b        = 32'h10203040;
      carry_in = 1'b0;
      i_valid  = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_byte2", 64'({alu_a, alu_b}), 64'(16'h0220));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_valid", 64'(o_valid), 64'd0);
      check("abort_result", 64'(o_result), 64'd0);
      check("abort_alu", 64'({alu_a, alu_b, alu_op, alu_cin}), 64'd0);
      check("abort_ready", 64'(o_ready), 64'd1);
      @(posedge clk); #1;
      repeat (6) @(posedge clk);
      #1;
      run_op(3'b000, 32'h01020304, 32'h10203040, 1'b0, r, c, g, z);
      check("post_reset_add", 64'({r, c}), 64'({32'h11223344, 1'b0}));

      repeat (3) @(posedge clk);
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
